// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   DEF_DATA_WIDTH : default parallel word width / data bits per frame.
//   tx_state_e     : transmit FSM states, gray-style encoding.
//   PAR_EVEN/ODD   : PAR_TYP values.
package uart_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b010,
        ST_STOP   = 3'b110
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: controller-to-serializer handshake and serial line.
//   P_DATA     : parallel word to send (controller -> serializer)
//   DATA_VALID : single-cycle send request (controller -> serializer)
//   PAR_EN     : insert parity bit (controller -> serializer)
//   PAR_TYP    : 0 = even, 1 = odd (controller -> serializer)
//   TX_OUT     : serial line, idle high (serializer -> line)
//   Busy       : frame on the line (serializer -> controller)
// master = controller side, slave = serializer side.
interface uart_tx_frame_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: parity bit for a latched data word.
//   data_i     : latched data word
//   par_typ_i  : PAR_EVEN or PAR_ODD
//   parity_o   : bit making the total count of ones even/odd
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    always_comb begin
        parity_o = (par_typ_i == PAR_EVEN) ? ^data_i : ~(^data_i);
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit serializer, one serial bit per CLK.
//   CLK  : bit clock
//   RST  : asynchronous active-low reset
//   bus  : uart_tx_frame_if.slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP in;
//          TX_OUT, Busy out)
// Frame: start(0), data LSB first, optional parity, stop(1).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_frame_if.slave   bus
);

    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_bit;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .parity_o  (par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.DATA_VALID) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line value
    // lines up with the state it belongs to, with no input-to-output path.
    // data_q/par_bit are already latched whenever DATA/PARITY is entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        unique case (state_d)
            ST_IDLE:   begin tx_d = 1'b1;          busy_d = 1'b0; end
            ST_START:  begin tx_d = 1'b0;          busy_d = 1'b1; end
            ST_DATA:   begin tx_d = data_q[cnt_d]; busy_d = 1'b1; end
            ST_PARITY: begin tx_d = par_bit;       busy_d = 1'b1; end
            ST_STOP:   begin tx_d = 1'b1;          busy_d = 1'b1; end
            default:   begin tx_d = 1'b1;          busy_d = 1'b0; end
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed, table-driven bench for uart_tx_frame.
// Expected line sequences are written out by hand, first bit in seq[10].
module tb_uart_tx_frame;

    logic clk;
    logic rst_n;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        int          len;
        logic [10:0] seq;
    } vec_t;

    vec_t vecs[7];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Call at a negedge with the DUT idle. Leaves the bench at the negedge of
    // the single idle cycle after the stop bit, so a following call models
    // the controller asserting DATA_VALID in the first Busy=0 cycle.
    task automatic run_frame(input string name, input logic [7:0] data,
                             input logic pen, input logic ptyp,
                             input int len, input logic [10:0] seq,
                             input int inject);
        bus.P_DATA     = data;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.DATA_VALID = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) bus.DATA_VALID = 1'b0;
            check($sformatf("%s tx[%0d]", name, i), bus.TX_OUT, seq[10-i]);
            check($sformatf("%s busy[%0d]", name, i), bus.Busy, 1'b1);
            if (i == inject) begin
                bus.DATA_VALID = 1'b1;
                bus.P_DATA     = 8'hFF;
                bus.PAR_TYP    = ~ptyp;
                bus.PAR_EN     = ~pen;
            end else if (inject >= 0 && i == inject + 1) begin
                bus.DATA_VALID = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("%s idle tx", name), bus.TX_OUT, 1'b1);
        check($sformatf("%s idle busy", name), bus.Busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"A5_nopar",  8'hA5, 1'b0, 1'b0, 10, 11'b01010010110};
        vecs[1] = '{"A5_even",   8'hA5, 1'b1, 1'b0, 11, 11'b01010010101};
        vecs[2] = '{"A5_odd",    8'hA5, 1'b1, 1'b1, 11, 11'b01010010111};
        vecs[3] = '{"07_even",   8'h07, 1'b1, 1'b0, 11, 11'b01110000011};
        vecs[4] = '{"07_nopar",  8'h07, 1'b0, 1'b0, 10, 11'b01110000010};
        vecs[5] = '{"3C_odd",    8'h3C, 1'b1, 1'b1, 11, 11'b00011110011};
        vecs[6] = '{"FF_even",   8'hFF, 1'b1, 1'b0, 11, 11'b01111111101};

        rst_n          = 1'b0;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = '0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        // Reset held, then released idle.
        repeat (3) begin
            @(negedge clk);
            check("reset tx", bus.TX_OUT, 1'b1);
            check("reset busy", bus.Busy, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle tx[%0d]", i), bus.TX_OUT, 1'b1);
            check($sformatf("idle busy[%0d]", i), bus.Busy, 1'b0);
        end

        // Table of single frames.
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].name, vecs[v].data, vecs[v].par_en,
                      vecs[v].par_typ, vecs[v].len, vecs[v].seq, -1);
            repeat (2) @(negedge clk);
        end

        // DATA_VALID with 8'hFF and changed PAR_EN/PAR_TYP in frame cycle 4:
        // the 3C frame is unaffected and nothing follows it.
        run_frame("3C_inject", 8'h3C, 1'b1, 1'b1, 11, 11'b00011110011, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post-inject tx[%0d]", i), bus.TX_OUT, 1'b1);
            check($sformatf("post-inject busy[%0d]", i), bus.Busy, 1'b0);
        end

        // Back-to-back: AA requested in the single idle cycle after 55.
        run_frame("55_b2b", 8'h55, 1'b0, 1'b0, 10, 11'b01010101010, -1);
        run_frame("AA_b2b", 8'hAA, 1'b0, 1'b0, 10, 11'b00101010110, -1);
        repeat (2) @(negedge clk);

        // Reset while data bit 3 of A5 (a 0) is on the line.
        bus.P_DATA     = 8'hA5;
        bus.PAR_EN     = 1'b0;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset bit3 tx", bus.TX_OUT, 1'b0);
        check("pre-reset busy", bus.Busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx", bus.TX_OUT, 1'b1);
        check("async reset busy", bus.Busy, 1'b0);
        @(negedge clk);
        check("reset hold tx", bus.TX_OUT, 1'b1);
        check("reset hold busy", bus.Busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset tx", bus.TX_OUT, 1'b1);
        check("post-reset busy", bus.Busy, 1'b0);
        run_frame("81_even", 8'h81, 1'b1, 1'b0, 11, 11'b01000000101, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
